quad_enc_bank: RTL

- Parametrised multi-channel quadrature encoder front end: synchroniser, decoder, counter and multiplexed display-nibble scanner in one block.
- Generalises the two-encoder / 8-bit / 4-digit front panel to NUM_CH channels of CNT_W bits each.
- Adds selectable x1/x4 counting, wrap/saturate arithmetic, per-channel clear and an illegal-transition flag.
- Sits between the encoder pins and the decode2/decode7 display drivers.

---
 rtl/quad_enc_bank.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/quad_enc_bank.sv
// Multi-channel quadrature encoder front end: 2-FF sync, gray-code step decode,
// wrap/saturate counters and a scanned display-nibble mux. Optional QENC_GLITCH_FILTER_EN.
module quad_enc_bank #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 8,
  parameter int SAT      = 0,
  parameter int X4       = 1,
  parameter int DIV_W    = 14,
  parameter int FILT_LEN = 8,
  localparam int NUM_DIG = NUM_CH * CNT_W / 4,
  localparam int DIG_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1
) (
  input  logic                    CLOCK_50,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       enc_a,
  input  logic [NUM_CH-1:0]       enc_b,
  input  logic [NUM_CH-1:0]       clr,
  output logic [NUM_CH-1:0]       cw,
  output logic [NUM_CH-1:0]       ccw,
  output logic [NUM_CH-1:0]       err,
  output logic [NUM_CH*CNT_W-1:0] counts,
  output logic [DIG_W-1:0]        digit,
  output logic [3:0]              disp_digit
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifndef QENC_GLITCH_FILTER_EN
  localparam int unused_filt_len = FILT_LEN;
`endif

  logic [NUM_CH-1:0] a_s1_q, a_s2_q, b_s1_q, b_s2_q;

  // Pins idle high, so the synchronisers reset to 1 and release produces no step.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      a_s1_q <= '1;
      a_s2_q <= '1;
      b_s1_q <= '1;
      b_s2_q <= '1;
    end else begin
      a_s1_q <= enc_a;
      a_s2_q <= a_s1_q;
      b_s1_q <= enc_b;
      b_s2_q <= b_s1_q;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [1:0]       raw;
    logic [1:0]       cur;
    logic [1:0]       prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cw_q, cw_d, ccw_q, ccw_d, err_q, err_d;
    logic             fwd, rev, bad, cnt_ok;

    assign raw = {a_s2_q[c], b_s2_q[c]};

`ifdef QENC_GLITCH_FILTER_EN
    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    logic [1:0]    filt_q;
    logic [FW-1:0] fcnt_q [2];

    // A pin level is accepted only after it has disagreed with the filtered level FILT_LEN clocks in a row.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
        filt_q    <= 2'b11;
        fcnt_q[0] <= '0;
        fcnt_q[1] <= '0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (raw[p] == filt_q[p]) begin
            fcnt_q[p] <= '0;
          end else if (fcnt_q[p] == FW'(FILT_LEN - 1)) begin
            filt_q[p] <= raw[p];
            fcnt_q[p] <= '0;
          end else begin
            fcnt_q[p] <= fcnt_q[p] + FW'(1);
          end
        end
      end
    end

    assign cur = filt_q;
`else
    assign cur = raw;
`endif

    always_comb begin
      fwd = 1'b0;
      rev = 1'b0;
      bad = 1'b0;
      case ({prev_q, cur})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd = 1'b1;
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: rev = 1'b1;
        4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: bad = 1'b1;
        default:                                fwd = 1'b0;
      endcase
    end

    // In x1 mode only the transition into the detent (00) is counted.
    assign cnt_ok = (X4 != 0) || (cur == 2'b00);

    always_comb begin
      cnt_d = cnt_q;
      cw_d  = 1'b0;
      ccw_d = 1'b0;
      err_d = err_q;
      if (clr[c]) begin
        cnt_d = '0;
        err_d = 1'b0;
      end else if (bad) begin
        err_d = 1'b1;
      end else if (fwd && cnt_ok) begin
        cw_d = 1'b1;
        if ((SAT != 0) && (cnt_q == '1)) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else if (rev && cnt_ok) begin
        ccw_d = 1'b1;
        if ((SAT != 0) && (cnt_q == '0)) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end else begin
        cnt_d = cnt_q;
      end
    end

    // prev follows the decoder input every cycle, even under clr or an illegal jump.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
        prev_q <= 2'b11;
        cnt_q  <= '0;
        cw_q   <= 1'b0;
        ccw_q  <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        prev_q <= cur;
        cnt_q  <= cnt_d;
        cw_q   <= cw_d;
        ccw_q  <= ccw_d;
        err_q  <= err_d;
      end
    end

    assign counts[c*CNT_W +: CNT_W] = cnt_q;
    assign cw[c]                    = cw_q;
    assign ccw[c]                   = ccw_q;
    assign err[c]                   = err_q;
  end

  logic [DIV_W-1:0] div_q;
  logic [DIG_W-1:0] digit_q;

  // Digit index advances on prescaler wrap and folds back after the last digit.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      digit_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
      if (div_q == '1) begin
        if (digit_q == DIG_W'(NUM_DIG - 1)) begin
          digit_q <= '0;
        end else begin
          digit_q <= digit_q + DIG_W'(1);
        end
      end else begin
        digit_q <= digit_q;
      end
    end
  end

  assign digit = digit_q;

  logic [NUM_CH*CNT_W-1:0] vec;

  // Display vector puts channel 0 in the most significant nibbles.
  always_comb begin
    vec = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      vec[(NUM_CH-1-c)*CNT_W +: CNT_W] = counts[c*CNT_W +: CNT_W];
    end
  end

  always_comb begin
    disp_digit = 4'h0;
    for (int d = 0; d < NUM_DIG; d++) begin
      if (digit_q == DIG_W'(d)) begin
        disp_digit = vec[d*4 +: 4];
      end else begin
        disp_digit = disp_digit;
      end
    end
  end

endmodule
